bg_scroll_ctrl: RTL and testbench
=================================

# bg_scroll_ctrl

Controller that drives the 128x128 background ROM from the VGA pixel stream. It maps 640x480 pixel coordinates to 4x-scaled ROM coordinates and adds a horizontal scroll offset. The offset advances once per frame during vertical blank at a programmable sub-pixel speed. It delays video_on and the syncs so they arrive aligned with the ROM color output. It sits between the VGA sync generator and the background ROM, under control of the game FSM (start/pause/stop).

## Interface
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- SCALE_SHIFT, 2: log2 of the pixel-to-ROM-texel scale factor.
- ROM_LAT, 2: ROM read latency in cycles from x/y to color (address register plus data register).
- SPEED_W, 4: width of the speed input. The scroll accumulator uses 7 integer bits and SPEED_W fraction bits.

- clk  in  1  pixel clock; one pixel per cycle.
- reset  in  1  asynchronous, active-high reset.
- pixel_x  in  10  current pixel column from the sync generator.
- pixel_y  in  10  current pixel row from the sync generator.
- video_on_in  in  1  active-region flag from the sync generator.
- hsync_in  in  1  horizontal sync from the sync generator.
- vsync_in  in  1  vertical sync from the sync generator.
- start  in  1  pulse; IDLE->RUN.
- pause_tog  in  1  pulse; toggles RUN<->PAUSE.
- stop  in  1  pulse; any state->IDLE and clears scroll.
- speed  in  SPEED_W  scroll increment per frame, in 1/2^SPEED_W texel units.
- rom_x  out  7  ROM column; connects to the ROM x input.
- rom_y  out  7  ROM row; connects to the ROM y input.
- rom_en  out  1  ROM enable; connects to the ROM video_on input.
- video_on_out  out  1  video_on_in delayed to align with ROM color.
- hsync_out  out  1  hsync_in delayed to align with ROM color.
- vsync_out  out  1  vsync_in delayed to align with ROM color.
- scroll_pos  out  7  integer part of the scroll accumulator.
- frame_tick  out  1  one-cycle pulse on every vblank-start edge, in all states.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - PAUSE.
- State transitions:
  - IDLE: start -> RUN.
  - RUN: pause_tog -> PAUSE.
  - PAUSE: pause_tog -> RUN.
  - stop from any state -> IDLE, and the scroll accumulator clears to 0 on the same clock edge.
  - Priority: stop > start > pause_tog. start in RUN or PAUSE is ignored; pause_tog in IDLE is ignored.
- Vblank edge: the cycle where pixel_y == V_ACTIVE and pixel_x == 0.
  - On the edge, frame_tick pulses.
  - If the state is RUN, acc <= acc + speed, modulo 2^(7+SPEED_W). The accumulator wraps silently.
  - The accumulator never changes during active video, so frames do not tear.
- Coordinate map (registered):
  - rom_x <= ((pixel_x >> SCALE_SHIFT) + scroll_pos) mod 128, using 7-bit truncation.
  - rom_y <= (pixel_y >> SCALE_SHIFT) mod 128.
- rom_en <= (pixel_y < V_ACTIVE).
  - The ROM pipeline flows through horizontal blank, so the first active pixel of each line is never stale.
  - rom_en is held low through vertical blank.
- Reset behaviour: reset asserted at any time forces all of the following immediately, regardless of clk:
  - state IDLE, accumulator 0.
  - rom_x, rom_y, rom_en = 0.
  - Delay lines and video_on_out, hsync_out, vsync_out = 0.
  - frame_tick = 0.
  - The syncs therefore read 0 for up to 3 cycles after reset release; this is acceptable.

## Timing
- Latency from pixel inputs to rom_x/rom_y/rom_en: 1 cycle.
- Latency from pixel inputs to ROM color: 1 + ROM_LAT = 3 cycles.
- video_on_out, hsync_out and vsync_out equal their inputs delayed by 1 + ROM_LAT cycles, via a shift register.
- scroll_pos updates on the clock edge ending the vblank-edge cycle. It is visible in rom_x from the next cycle.
- frame_tick is registered: it is high for the cycle after the vblank-edge cycle.
- When stop and a vblank edge coincide, the result is acc = 0 and no increment is applied. frame_tick still pulses.
- A pause_tog arriving in the same cycle as a vblank edge uses the pre-transition state to decide the increment.

## Test plan
- Reset, then pixel_x=8, pixel_y=4 -> one cycle later rom_x=2, rom_y=1, rom_en=1, scroll_pos=0, all other outputs 0.
- start, speed=8, four vblank edges -> scroll_pos=2. Then pixel_x=0 -> rom_x=2. frame_tick pulses exactly 4 times.
- Preload to scroll_pos=127 (speed=15 and enough frames), then pixel_x=4 -> rom_x=0 (wrap). Accumulator overflow wraps to a small value with no stall.
- RUN at speed=8, pause_tog, three vblank edges -> scroll_pos unchanged. Second pause_tog, two edges -> scroll_pos +1.
- stop and pause_tog in the same cycle while in RUN -> state IDLE and scroll_pos=0 next cycle. A following start resumes from 0.
- video_on_in rises at cycle t -> video_on_out rises at t+3. hsync_out mirrors hsync_in with a 3-cycle delay. rom_en=0 for all of pixel_y 480..524. Async reset asserted mid-line clears all outputs without a clock edge.

Source files
------------

// File: rtl/bg_scroll_ctrl.sv
// bg_scroll_ctrl: maps VGA pixel coordinates onto the 4x-scaled 128x128
// background ROM with a horizontal scroll offset. The offset advances once per
// frame on the vblank edge. Video flags are delayed to line up with ROM color.
module bg_scroll_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int ROM_LAT     = 2,
    parameter int SPEED_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               start,
    input  logic               pause_tog,
    input  logic               stop,
    input  logic [SPEED_W-1:0] speed,
    output logic [6:0]         rom_x,
    output logic [6:0]         rom_y,
    output logic               rom_en,
    output logic               video_on_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [6:0]         scroll_pos,
    output logic               frame_tick
);

    localparam int ACC_W = 7 + SPEED_W;
    localparam int DLY   = 1 + ROM_LAT;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [6:0]       rom_x_q, rom_x_d;
    logic [6:0]       rom_y_q, rom_y_d;
    logic             rom_en_q, rom_en_d;
    logic             frame_tick_q;
    logic [DLY-1:0]   von_q, hs_q, vs_q;
    logic             vblank_edge;

    assign vblank_edge = (pixel_y == V_ACT_L) && (pixel_x == '0);
    assign scroll_pos  = acc_q[ACC_W-1:SPEED_W];

    // Game control FSM: stop beats start beats pause_tog.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start)     state_d = ST_RUN;
                ST_RUN:   if (pause_tog) state_d = ST_PAUSE;
                ST_PAUSE: if (pause_tog) state_d = ST_RUN;
                default:                 state_d = ST_IDLE;
            endcase
        end
    end

    // Scroll accumulator: cleared by stop, advanced only on the vblank edge
    // while running (pre-transition state), wrapping modulo 2^ACC_W.
    always_comb begin
        acc_d = acc_q;
        if (stop) begin
            acc_d = '0;
        end else if (vblank_edge && (state_q == ST_RUN)) begin
            acc_d = acc_q + ACC_W'(speed);
        end
    end

    // Coordinate map; the pipeline keeps flowing through hblank so the first
    // pixel of each line is fresh, and rom_en only drops in vblank.
    always_comb begin
        rom_x_d  = 7'(pixel_x >> SCALE_SHIFT) + scroll_pos;
        rom_y_d  = 7'(pixel_y >> SCALE_SHIFT);
        rom_en_d = (pixel_y < V_ACT_L);
    end

    // Control state and scroll accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // ROM address/enable registers and the registered frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_x_q      <= '0;
            rom_y_q      <= '0;
            rom_en_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            rom_x_q      <= rom_x_d;
            rom_y_q      <= rom_y_d;
            rom_en_q     <= rom_en_d;
            frame_tick_q <= vblank_edge;
        end
    end

    // Delay lines matching address register plus ROM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            von_q <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
        end else begin
            von_q <= {von_q[DLY-2:0], video_on_in};
            hs_q  <= {hs_q[DLY-2:0], hsync_in};
            vs_q  <= {vs_q[DLY-2:0], vsync_in};
        end
    end

    assign rom_x        = rom_x_q;
    assign rom_y        = rom_y_q;
    assign rom_en       = rom_en_q;
    assign frame_tick   = frame_tick_q;
    assign video_on_out = von_q[DLY-1];
    assign hsync_out    = hs_q[DLY-1];
    assign vsync_out    = vs_q[DLY-1];

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Testbench for bg_scroll_ctrl: directed scenarios plus randomized traffic,
// each compared against an arithmetic reference model of the scroller.
module tb_bg_scroll_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on_in, hsync_in, vsync_in;
    logic       start, pause_tog, stop;
    logic [3:0] speed;
    logic [6:0] rom_x, rom_y, scroll_pos;
    logic       rom_en, video_on_out, hsync_out, vsync_out, frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: accumulator as an integer in 1/16 texel units,
    // state as 0=idle 1=run 2=pause, flag history as a queue.
    int       m_acc;
    int       m_state;
    int       m_rx, m_ry, m_en, m_tick;
    logic [2:0] m_dq[$];
    logic [2:0] m_dly;

    bg_scroll_ctrl #(
        .H_ACTIVE(640), .V_ACTIVE(480), .SCALE_SHIFT(2), .ROM_LAT(2), .SPEED_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .start(start), .pause_tog(pause_tog), .stop(stop), .speed(speed),
        .rom_x(rom_x), .rom_y(rom_y), .rom_en(rom_en),
        .video_on_out(video_on_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .scroll_pos(scroll_pos), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 0; m_state = 0; m_rx = 0; m_ry = 0; m_en = 0; m_tick = 0;
        m_dq.delete();
        m_dly = 3'b000;
    endtask

    // One clock edge; the model consumes the inputs the DUT just sampled.
    task automatic tick();
        int px, py, vb;
        @(posedge clk);
        #1;
        px = int'(pixel_x);
        py = int'(pixel_y);
        vb = (py == 480 && px == 0) ? 1 : 0;
        m_rx   = (px / 4 + m_acc / 16) % 128;
        m_ry   = (py / 4) % 128;
        m_en   = (py < 480) ? 1 : 0;
        m_tick = vb;
        if (stop) begin
            m_acc = 0;
            m_state = 0;
        end else begin
            if (vb == 1 && m_state == 1) m_acc = (m_acc + int'(speed)) % 2048;
            if (start && m_state == 0) m_state = 1;
            else if (pause_tog && m_state != 0) m_state = 3 - m_state;
        end
        m_dq.push_back({video_on_in, hsync_in, vsync_in});
        if (m_dq.size() > 3) void'(m_dq.pop_front());
        m_dly = (m_dq.size() == 3) ? m_dq[0] : 3'b000;
    endtask

    task automatic do_vblank();
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        tick();
        pixel_x = 10'($urandom_range(1, 799));
        pixel_y = 10'($urandom_range(0, 479));
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_tog = 1'b1; tick(); pause_tog = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pixel_x = 10'd8; pixel_y = 10'd4;
        video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        start = 1'b0; pause_tog = 1'b0; stop = 1'b0; speed = 4'd0;
        model_reset();
        #2;
        checks++;
        if ({rom_x, rom_y, rom_en, scroll_pos, frame_tick, video_on_out, hsync_out, vsync_out} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h required all zero", {rom_x, rom_y, rom_en, scroll_pos, frame_tick});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        checks++; if (rom_x !== 7'd2) begin errors++; $display("FAIL reset_rom_x: got %0d required 2", rom_x); end
        checks++; if (rom_y !== 7'd1) begin errors++; $display("FAIL reset_rom_y: got %0d required 1", rom_y); end
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL reset_rom_en: got %0b required 1", rom_en); end
        checks++; if (scroll_pos !== 7'd0) begin errors++; $display("FAIL reset_scroll: got %0d required 0", scroll_pos); end
        checks++;
        if ({frame_tick, video_on_out, hsync_out, vsync_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_others: got %b required 0000", {frame_tick, video_on_out, hsync_out, vsync_out});
        end
    endtask

    task automatic test_scroll();
        int ticks;
        ticks = 0;
        pulse_start();
        speed = 4'd8;
        for (int i = 0; i < 4; i++) begin
            do_vblank();
            if (frame_tick === 1'b1) ticks++;
            tick();
            if (frame_tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 4) begin errors++; $display("FAIL scroll_ticks: got %0d required 4", ticks); end
        checks++; if (scroll_pos !== 7'd2) begin errors++; $display("FAIL scroll_pos4: got %0d required 2", scroll_pos); end
        pixel_x = 10'd0; pixel_y = 10'd20;
        tick();
        checks++; if (rom_x !== 7'd2) begin errors++; $display("FAIL scroll_rom_x: got %0d required 2", rom_x); end
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        pulse_stop();
        pulse_start();
        speed = 4'd15;
        while ((m_acc / 16) != 127 && n < 300) begin
            do_vblank();
            n++;
        end
        checks++; if (scroll_pos !== 7'd127) begin errors++; $display("FAIL wrap_preload: got %0d required 127", scroll_pos); end
        pixel_x = 10'd4; pixel_y = 10'd8;
        tick();
        checks++; if (rom_x !== 7'd0) begin errors++; $display("FAIL wrap_rom_x: got %0d required 0", rom_x); end
        do_vblank();
        checks++; if (scroll_pos !== 7'd0) begin errors++; $display("FAIL wrap_acc: got %0d required 0", scroll_pos); end
        checks++; if (int'(scroll_pos) != m_acc / 16) begin errors++; $display("FAIL wrap_model: got %0d required %0d", scroll_pos, m_acc / 16); end
    endtask

    task automatic test_pause();
        pulse_stop();
        pulse_start();
        speed = 4'd8;
        do_vblank(); do_vblank();
        checks++; if (scroll_pos !== 7'd1) begin errors++; $display("FAIL pause_run: got %0d required 1", scroll_pos); end
        pulse_pause();
        repeat (3) do_vblank();
        checks++; if (scroll_pos !== 7'd1) begin errors++; $display("FAIL pause_hold: got %0d required 1", scroll_pos); end
        pulse_pause();
        do_vblank(); do_vblank();
        checks++; if (scroll_pos !== 7'd2) begin errors++; $display("FAIL pause_resume: got %0d required 2", scroll_pos); end
        // pause_tog coinciding with vblank while running: increment applies
        pause_tog = 1'b1; do_vblank(); pause_tog = 1'b0;
        do_vblank();
        pulse_pause();
        do_vblank();
        checks++; if (scroll_pos !== 7'd3) begin errors++; $display("FAIL pause_coinc_run: got %0d required 3", scroll_pos); end
        // resume coinciding with vblank while paused: no increment
        pulse_pause();
        pause_tog = 1'b1; do_vblank(); pause_tog = 1'b0;
        do_vblank();
        checks++; if (scroll_pos !== 7'd3) begin errors++; $display("FAIL pause_coinc_pause: got %0d required 3", scroll_pos); end
    endtask

    task automatic test_stop_pause();
        stop = 1'b1; pause_tog = 1'b1;
        tick();
        stop = 1'b0; pause_tog = 1'b0;
        checks++; if (scroll_pos !== 7'd0) begin errors++; $display("FAIL stop_clear: got %0d required 0", scroll_pos); end
        do_vblank();
        checks++; if (scroll_pos !== 7'd0) begin errors++; $display("FAIL stop_idle: got %0d required 0", scroll_pos); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL stop_idle_tick: got %0b required 1", frame_tick); end
        pulse_start();
        speed = 4'd8;
        do_vblank(); do_vblank();
        checks++; if (scroll_pos !== 7'd1) begin errors++; $display("FAIL stop_restart: got %0d required 1", scroll_pos); end
        stop = 1'b1; do_vblank(); stop = 1'b0;
        checks++; if (scroll_pos !== 7'd0) begin errors++; $display("FAIL stop_vblank: got %0d required 0", scroll_pos); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL stop_vblank_tick: got %0b required 1", frame_tick); end
        tick();
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %0b required 0", frame_tick); end
    endtask

    task automatic test_delay();
        video_on_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (4) tick();
        video_on_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i >= 4) begin
                video_on_in = 1'($urandom_range(0, 1));
                hsync_in    = 1'($urandom_range(0, 1));
                vsync_in    = 1'($urandom_range(0, 1));
            end
            checks++;
            if ({video_on_out, hsync_out, vsync_out} !== m_dly) begin
                errors++;
                $display("FAIL delay_flags cycle %0d: got %b required %b", i, {video_on_out, hsync_out, vsync_out}, m_dly);
            end
        end
        for (int y = 480; y < 525; y++) begin
            pixel_y = 10'(y);
            pixel_x = 10'($urandom_range(0, 799));
            tick();
            checks++;
            if (rom_en !== 1'b0) begin errors++; $display("FAIL vblank_rom_en y=%0d: got %0b required 0", y, rom_en); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                pixel_x = 10'd0; pixel_y = 10'd480;
            end else begin
                pixel_x = 10'($urandom_range(0, 799));
                pixel_y = 10'($urandom_range(0, 524));
            end
            video_on_in = 1'($urandom_range(0, 1));
            hsync_in    = 1'($urandom_range(0, 1));
            vsync_in    = 1'($urandom_range(0, 1));
            start       = ($urandom_range(0, 19) == 0);
            pause_tog   = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 59) == 0);
            speed       = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (int'(rom_x) != m_rx || int'(rom_y) != m_ry || int'(rom_en) != m_en) begin
                errors++;
                $display("FAIL rand_addr cycle %0d: got x=%0d y=%0d en=%0b required x=%0d y=%0d en=%0d",
                         i, rom_x, rom_y, rom_en, m_rx, m_ry, m_en);
            end
            checks++;
            if (int'(scroll_pos) != m_acc / 16 || int'(frame_tick) != m_tick) begin
                errors++;
                $display("FAIL rand_scroll cycle %0d: got pos=%0d tick=%0b required pos=%0d tick=%0d",
                         i, scroll_pos, frame_tick, m_acc / 16, m_tick);
            end
            checks++;
            if ({video_on_out, hsync_out, vsync_out} !== m_dly) begin
                errors++;
                $display("FAIL rand_flags cycle %0d: got %b required %b", i, {video_on_out, hsync_out, vsync_out}, m_dly);
            end
        end
        start = 1'b0; pause_tog = 1'b0; stop = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse_stop();
        pulse_start();
        speed = 4'd15;
        repeat (3) do_vblank();
        video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        pixel_x = 10'd300; pixel_y = 10'd200;
        repeat (4) tick();
        checks++; if (scroll_pos === 7'd0) begin errors++; $display("FAIL async_pre: got %0d required nonzero", scroll_pos); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rom_x, rom_y, rom_en, scroll_pos, frame_tick, video_on_out, hsync_out, vsync_out} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h required all zero",
                     {rom_x, rom_y, rom_en, scroll_pos, frame_tick, video_on_out, hsync_out, vsync_out});
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_wrap();
        test_pause();
        test_stop_pause();
        test_delay();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
